// File: rtl/aes_mix_columns_pkg.sv
// GF(2^8) helpers shared by the MixColumns datapath.
// Multiplies by AES coefficients using the xtime chain only.
package aes_pkg;

   localparam logic [7:0] GF_REDUCE = 8'h1B;

   typedef logic [7:0] gf_byte_t;

   typedef enum logic [3:0] {
      GF_X2 = 4'h2,
      GF_X3 = 4'h3,
      GF_X9 = 4'h9,
      GF_XB = 4'hB,
      GF_XD = 4'hD,
      GF_XE = 4'hE
   } gf_coef_e;

   function automatic gf_byte_t xtime(input gf_byte_t b);
      return {b[6:0], 1'b0} ^ (b[7] ? GF_REDUCE : 8'h00);
   endfunction

   function automatic gf_byte_t gf_mul_const(input gf_byte_t b, input gf_coef_e c);
      gf_byte_t x2;
      gf_byte_t x4;
      gf_byte_t x8;
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      case (c)
         GF_X2:   return x2;
         GF_X3:   return x2 ^ b;
         GF_X9:   return x8 ^ b;
         GF_XB:   return x8 ^ x2 ^ b;
         GF_XD:   return x8 ^ x4 ^ b;
         GF_XE:   return x8 ^ x4 ^ x2;
         default: return b;
      endcase
   endfunction

endpackage

// File: rtl/aes_mix_columns_if.sv
// Data/valid bundle for the MixColumns stage.
interface aes_mix_columns_if;
   logic         iValid;
   logic         iInv;
   logic [127:0] iData;
   logic         oValid;
   logic [127:0] oData;

   modport master (output iValid, output iInv, output iData, input oValid, input oData);
   modport slave  (input iValid, input iInv, input iData, output oValid, output oData);
endinterface

// File: rtl/aes_mix_single_column.sv
// Combinational (Inv)MixColumns for one 32-bit column, a0 in the MSB byte.
module aes_mix_single_column
   import aes_pkg::*;
(
   input  logic [31:0] col,
   input  logic        inv,
   output logic [31:0] res
);

   gf_byte_t a0, a1, a2, a3;

   assign a0 = col[31:24];
   assign a1 = col[23:16];
   assign a2 = col[15:8];
   assign a3 = col[7:0];

   always_comb begin
      res = '0;
      if (inv) begin
         res = {gf_mul_const(a0, GF_XE) ^ gf_mul_const(a1, GF_XB) ^ gf_mul_const(a2, GF_XD) ^ gf_mul_const(a3, GF_X9),
                gf_mul_const(a0, GF_X9) ^ gf_mul_const(a1, GF_XE) ^ gf_mul_const(a2, GF_XB) ^ gf_mul_const(a3, GF_XD),
                gf_mul_const(a0, GF_XD) ^ gf_mul_const(a1, GF_X9) ^ gf_mul_const(a2, GF_XE) ^ gf_mul_const(a3, GF_XB),
                gf_mul_const(a0, GF_XB) ^ gf_mul_const(a1, GF_XD) ^ gf_mul_const(a2, GF_X9) ^ gf_mul_const(a3, GF_XE)};
      end else begin
         res = {gf_mul_const(a0, GF_X2) ^ gf_mul_const(a1, GF_X3) ^ a2 ^ a3,
                a0 ^ gf_mul_const(a1, GF_X2) ^ gf_mul_const(a2, GF_X3) ^ a3,
                a0 ^ a1 ^ gf_mul_const(a2, GF_X2) ^ gf_mul_const(a3, GF_X3),
                gf_mul_const(a0, GF_X3) ^ a1 ^ a2 ^ gf_mul_const(a3, GF_X2)};
      end
   end

endmodule

// File: rtl/aes_mix_columns.sv
// MixColumns / InvMixColumns on a 128-bit AES state with one output register.
module aes_mix_columns
   import aes_pkg::*;
#(
   parameter int unsigned INV_EN = 1
) (
   input  logic              iClk,
   input  logic              iRst,
   aes_mix_columns_if.slave  bus
);

   logic         inv_sel;
   logic [127:0] mixed;
   logic         valid_q;
   logic [127:0] data_q;

   assign inv_sel = (INV_EN != 0) && bus.iInv;

   for (genvar c = 0; c < 4; c++) begin : g_col
      aes_mix_single_column u_col (
         .col (bus.iData[127-32*c -: 32]),
         .inv (inv_sel),
         .res (mixed[127-32*c -: 32])
      );
   end

   // oData keeps the last result across idle beats; only valid moves.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= bus.iValid;
         if (bus.iValid) data_q <= mixed;
      end
   end

   assign bus.oValid = valid_q;
   assign bus.oData  = data_q;

endmodule

// File: tb/tb_aes_mix_columns.sv
// Self-checking bench: random beats vs a polynomial-arithmetic model, KATs, reset.
module tb_aes_mix_columns;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int unsigned total = 0;
   int unsigned bad   = 0;
   logic [127:0] exp_data = '0;

   aes_mix_columns_if bus ();
   aes_mix_columns_if bus_fwd ();

   aes_mix_columns #(.INV_EN(1)) dut (.iClk(clk), .iRst(rst), .bus(bus));
   aes_mix_columns #(.INV_EN(0)) dut_fwd (.iClk(clk), .iRst(rst), .bus(bus_fwd));

   assign bus_fwd.iValid = bus.iValid;
   assign bus_fwd.iInv   = bus.iInv;
   assign bus_fwd.iData  = bus.iData;

   always #5 clk = ~clk;

   // Carry-less product followed by reduction modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [14:0] prod;
      prod = '0;
      for (int i = 0; i < 8; i++)
         if (b[i]) prod ^= (15'(a) << i);
      for (int k = 14; k >= 8; k--)
         if (prod[k]) prod ^= (15'h11B << (k - 8));
      return prod[7:0];
   endfunction

   // Circulant matrix product: row r uses the base row rotated right by r.
   function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
      logic [7:0]   base [4];
      logic [127:0] o;
      logic [7:0]   acc;
      if (inv) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      else     base = '{8'h02, 8'h03, 8'h01, 8'h01};
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            acc = '0;
            for (int k = 0; k < 4; k++)
               acc ^= gf_mul(base[(k - r + 4) % 4], s[127 - 8*(4*c + k) -: 8]);
            o[127 - 8*(4*c + r) -: 8] = acc;
         end
      return o;
   endfunction

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", tag, got, exp);
      end
   endtask

   task automatic beat(input logic v, input logic inv, input logic [127:0] d);
      @(negedge clk);
      bus.iValid = v;
      bus.iInv   = inv;
      bus.iData  = d;
      @(posedge clk);
      #1;
      if (v) exp_data = ref_mix(d, inv);
      chk("valid", {127'd0, bus.oValid}, {127'd0, v});
      chk("data", bus.oData, exp_data);
   endtask

   localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
   localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;

   initial begin
      logic [127:0] r;
      logic [127:0] f;
      bus.iValid = 1'b0;
      bus.iInv   = 1'b0;
      bus.iData  = '0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", {127'd0, bus.oValid}, '0);
      chk("rst_data", bus.oData, '0);
      @(negedge clk);
      rst = 1'b0;

      beat(1'b1, 1'b0, FIPS_IN);
      chk("kat_fwd", bus.oData, FIPS_OUT);
      beat(1'b1, 1'b1, FIPS_OUT);
      chk("kat_inv", bus.oData, FIPS_IN);
      beat(1'b1, 1'b0, 128'hdb135345_f20a225c_01010101_c6c6c6c6);
      chk("kat_col_a", bus.oData, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
      beat(1'b1, 1'b0, 128'hd4d4d4d5_2d26314c_db135345_f20a225c);
      chk("kat_col_b", bus.oData, 128'hd5d5d7d6_4d7ebdf8_8e4da1bc_9fdc589d);
      beat(1'b0, 1'b1, 128'h0);
      chk("hold", bus.oData, 128'hd5d5d7d6_4d7ebdf8_8e4da1bc_9fdc589d);

      beat(1'b1, 1'b1, FIPS_IN);
      chk("fwd_only_valid", {127'd0, bus_fwd.oValid}, 128'd1);
      chk("fwd_only_data", bus_fwd.oData, FIPS_OUT);

      for (int i = 0; i < 1000; i++) begin
         r = {$urandom, $urandom, $urandom, $urandom};
         beat(1'b1, 1'b0, r);
         f = bus.oData;
         beat(1'b1, 1'b1, f);
         chk("roundtrip", bus.oData, r);
         if ($urandom_range(0, 7) == 0)
            beat(1'b0, $urandom_range(0, 1) == 1, {$urandom, $urandom, $urandom, $urandom});
      end

      beat(1'b1, 1'b0, {$urandom, $urandom, $urandom, $urandom});
      #2 rst = 1'b1;
      #1;
      chk("midrst_valid", {127'd0, bus.oValid}, '0);
      chk("midrst_data", bus.oData, '0);
      rst = 1'b0;
      exp_data = '0;
      repeat (3) beat(1'b0, 1'b0, {$urandom, $urandom, $urandom, $urandom});
      beat(1'b1, 1'b0, FIPS_IN);
      chk("after_rst", bus.oData, FIPS_OUT);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
